difftest_gfifo_ctrl: RTL and testbench

// - Emulation-side (Palladium GFIFO) replacement for the per-cycle simv_nstep DPI call in the sim top.
// - Collects the per-cycle difftest commit step count and queues non-zero counts toward the host checker through a valid/ready stream.
// - Returns the host's pass/fail verdict as a sticky simv_result flag; the top calls $finish when the flag is set.

---
 rtl/difftest_gfifo_ctrl.sv | 110 +++++++++++
 tb/tb_difftest_gfifo_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/difftest_gfifo_ctrl.sv
// Emulation-side step FIFO: coalesces per-cycle difftest commit counts into a
// registered valid/ready queue toward the host and latches the host verdict.
module difftest_gfifo_ctrl #(
  parameter int STEP_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int DEPTH      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [STEP_WIDTH-1:0]   step,
  output logic                    host_valid,
  input  logic                    host_ready,
  output logic [ACC_WIDTH-1:0]    host_data,
  input  logic                    host_resp_valid,
  input  logic                    host_resp_fail,
  output logic                    simv_result,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = PTR_W + 2;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);

  function automatic logic [ACC_WIDTH-1:0] sat_acc(input logic [ACC_WIDTH:0] v);
    return v[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : v[ACC_WIDTH-1:0];
  endfunction

  logic [ACC_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic                 result_q, result_d;
  logic                 ovf_q, ovf_d;

  logic                 empty, full, pop, push, resp_err, resp_dec;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] push_data_d;

  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == FULL_CNT);
    // A latched failure freezes the queue: nothing is offered to or taken from the host.
    host_valid  = !empty && !result_q;
    pop         = host_valid && host_ready;
    sum         = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
    push_data_d = sat_acc(sum);
    push        = 1'b0;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (!result_q && (sum != '0)) begin
      if (sum[ACC_WIDTH]) ovf_d = 1'b1;
      if (!full || pop) begin
        push  = 1'b1;
        acc_d = '0;
      end else begin
        acc_d = push_data_d;
      end
    end

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    // A verdict with nothing outstanding (and no pop covering it) is a protocol error.
    resp_err = host_resp_valid && (out_q == '0) && !pop;
    resp_dec = host_resp_valid && !resp_err;
    out_d    = out_q;
    if (pop && !resp_dec)      out_d = out_q + OUT_ONE;
    else if (!pop && resp_dec) out_d = out_q - OUT_ONE;
    result_d = result_q || resp_err || (host_resp_valid && host_resp_fail);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      result_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data_d;
  end

  assign host_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign simv_result = result_q;
  assign overflow    = ovf_q;
  assign pending     = count_q;

endmodule

// File: tb/tb_difftest_gfifo_ctrl.sv
// Scoreboard bench for difftest_gfifo_ctrl: a behavioural model queues the
// expected host entries as steps are driven and checks every head/pop.
module tb_difftest_gfifo_ctrl;

  localparam int DEPTH = 16;
  localparam int SAT   = 65535;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] step;
  logic       host_valid, host_ready;
  logic [15:0] host_data;
  logic       host_resp_valid, host_resp_fail;
  logic       simv_result, overflow;
  logic [4:0] pending;

  difftest_gfifo_ctrl #(.STEP_WIDTH(8), .ACC_WIDTH(16), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .step(step),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .host_resp_valid(host_resp_valid), .host_resp_fail(host_resp_fail),
    .simv_result(simv_result), .overflow(overflow), .pending(pending)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  int exp_q[$];
  int mcount, macc, mout;
  bit mres, movf;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    mcount = 0; macc = 0; mout = 0; mres = 0; movf = 0;
  endtask

  // Called at a falling edge: drive, check state outputs, advance model, run one clock.
  task automatic cyc(input int s, input bit rdy, input bit rv, input bit rf);
    bit mvalid, pop, push_ok, nres;
    int sum;
    step = s[7:0]; host_ready = rdy; host_resp_valid = rv; host_resp_fail = rf;
    #1;
    mvalid = (mcount != 0) && !mres;
    check_eq("host_valid", int'(host_valid), int'(mvalid));
    check_eq("pending", int'(pending), mcount);
    check_eq("simv_result", int'(simv_result), int'(mres));
    check_eq("overflow", int'(overflow), int'(movf));
    check_eq("host_data", int'(host_data), (mcount != 0) ? exp_q[0] : 0);

    pop = mvalid && rdy;
    if (pop) begin
      void'(exp_q.pop_front());
      mcount--;
    end
    sum = macc + s;
    if (!mres && sum != 0) begin
      if (sum > SAT) movf = 1;
      push_ok = (mcount < DEPTH) || pop;
      if (push_ok) begin
        exp_q.push_back((sum > SAT) ? SAT : sum);
        mcount++;
        macc = 0;
      end else begin
        macc = (sum > SAT) ? SAT : sum;
      end
    end
    nres = mres;
    if (rv && mout == 0 && !pop) nres = 1;
    else begin
      if (pop) mout++;
      if (rv) mout--;
    end
    if (rv && rf) nres = 1;
    mres = nres;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reset mid-cycle, away from any edge; outputs must clear immediately.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    check_eq("rst_host_valid", int'(host_valid), 0);
    check_eq("rst_host_data", int'(host_data), 0);
    check_eq("rst_simv_result", int'(simv_result), 0);
    check_eq("rst_overflow", int'(overflow), 0);
    check_eq("rst_pending", int'(pending), 0);
    model_clear();
    step = '0; host_ready = 1'b0; host_resp_valid = 1'b0; host_resp_fail = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    step = '0; host_ready = 1'b0; host_resp_valid = 1'b0; host_resp_fail = 1'b0;
    model_clear();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);

    // Single step, one-cycle latency, then popped.
    cyc(3, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);

    // Fill and coalesce: 16 entries of 1, then a coalesced 4.
    async_reset();
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);

    // Full FIFO with simultaneous push/pop of 5 each cycle.
    async_reset();
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(5, 1, 0, 0);
    for (int i = 0; i < 18; i++) cyc(0, 1, 0, 0);

    // Accumulator saturation sets overflow and queues the saturated count.
    async_reset();
    for (int i = 0; i < 290; i++) cyc(255, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);

    // Verdicts: pass then fail freezes the queue.
    async_reset();
    cyc(7, 0, 0, 0); cyc(8, 0, 0, 0); cyc(9, 0, 0, 0); cyc(10, 0, 0, 0);
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cyc(2, 1, 0, 0);

    // Response with nothing outstanding is a protocol error.
    async_reset();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(4, 1, 0, 0);

    // Live stream interrupted by reset.
    async_reset();
    for (int i = 1; i < 9; i++) cyc(i, i[0], 0, 0);
    async_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
